// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with enable and a prescaled auto-scan mode
// for digit/row multiplexing (7-segment anodes, keypad column strobes).
module scan_decoder #(
   parameter int unsigned SEL_W      = 2,
   parameter int unsigned PRESCALE   = 4,
   parameter int unsigned ACTIVE_LOW = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      in,
   output logic [2**SEL_W-1:0]   out,
   output logic [SEL_W-1:0]      sel_cur,
   output logic                  wrap
);

   localparam int unsigned OUT_W = 2 ** SEL_W;
   localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam bit          ACT_LO = (ACTIVE_LOW != 0);

   typedef enum logic [1:0] {StOff, StManual, StScan} state_e;

   state_e             state_q, state_d;
   logic [PRE_W-1:0]   pre_q, pre_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [OUT_W-1:0]   out_q, out_d;
   logic               wrap_q, wrap_d;
   logic [OUT_W-1:0]   dec;

   always_comb begin
      state_d = StOff;
      if (en) state_d = mode ? StScan : StManual;
   end

   always_comb begin
      pre_d  = '0;
      sel_d  = '0;
      wrap_d = 1'b0;
      unique case (state_d)
         StManual: sel_d = in;
         StScan: begin
            if (state_q != StScan) begin
               sel_d = '0;
            // Widen to 32 bits so the terminal-count compare never truncates.
            end else if (32'(pre_q) == PRESCALE - 1) begin
               sel_d  = sel_q + 1'b1;
               wrap_d = (sel_q == {SEL_W{1'b1}});
            end else begin
               pre_d = pre_q + 1'b1;
               sel_d = sel_q;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      dec        = '0;
      dec[sel_d] = 1'b1;
      if (state_d == StOff) out_d = {OUT_W{ACT_LO}};
      else                  out_d = dec ^ {OUT_W{ACT_LO}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StOff;
         pre_q   <= '0;
         sel_q   <= '0;
         out_q   <= {OUT_W{ACT_LO}};
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         sel_q   <= sel_d;
         out_q   <= out_d;
         wrap_q  <= wrap_d;
      end
   end

   assign out     = out_q;
   assign sel_cur = sel_q;
   assign wrap    = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: reset, manual sweep, scan timing, interruption
// and parameter corners across three instances.
module tb_scan_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       en0 = 1'b0, mode0 = 1'b0;
   logic [1:0] in0 = '0;
   logic [3:0] out0;
   logic [1:0] sel0;
   logic       wrap0;

   logic       en1 = 1'b0, mode1 = 1'b0;
   logic [0:0] in1 = '0;
   logic [1:0] out1;
   logic [0:0] sel1;
   logic       wrap1;

   logic       en3 = 1'b0, mode3 = 1'b0;
   logic [2:0] in3 = '0;
   logic [7:0] out3;
   logic [2:0] sel3;
   logic       wrap3;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   scan_decoder #(.SEL_W(2), .PRESCALE(3), .ACTIVE_LOW(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .en(en0), .mode(mode0), .in(in0),
      .out(out0), .sel_cur(sel0), .wrap(wrap0)
   );

   scan_decoder #(.SEL_W(1), .PRESCALE(1), .ACTIVE_LOW(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .in(in1),
      .out(out1), .sel_cur(sel1), .wrap(wrap1)
   );

   scan_decoder #(.SEL_W(3), .PRESCALE(4), .ACTIVE_LOW(0)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .in(in3),
      .out(out3), .sel_cur(sel3), .wrap(wrap3)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk0(input string tag, input logic [3:0] o, input logic [1:0] s,
                       input logic w);
      check({tag, ".out"}, 8'(out0), 8'(o));
      check({tag, ".sel"}, 8'(sel0), 8'(s));
      check({tag, ".wrap"}, 8'(wrap0), 8'(w));
   endtask

   initial begin
      logic [3:0] man_out [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

      // Reset state
      tick();
      tick();
      chk0("rst_init", 4'b0000, 2'd0, 1'b0);
      check("rst_init.out1", 8'(out1), 8'b11);
      rst_n = 1'b1;

      // Asynchronous reset mid-cycle from a non-zero output
      en0 = 1'b1; mode0 = 1'b0; in0 = 2'b11;
      tick();
      chk0("pre_rst", 4'b1000, 2'd3, 1'b0);
      #3 rst_n = 1'b0;
      #1 chk0("async_rst", 4'b0000, 2'd0, 1'b0);
      tick();
      chk0("rst_hold", 4'b0000, 2'd0, 1'b0);
      rst_n = 1'b1;

      // Manual sweep
      for (int i = 0; i < 4; i++) begin
         in0 = 2'(i);
         tick();
         chk0($sformatf("man%0d", i), man_out[i], 2'(i), 1'b0);
      end
      en0 = 1'b0;
      tick();
      chk0("man_off", 4'b0000, 2'd0, 1'b0);

      // Scan, 14 cycles from entry edge
      en0 = 1'b1; mode0 = 1'b1;
      for (int k = 0; k < 14; k++) begin
         tick();
         chk0($sformatf("scan%0d", k), 4'b0001 << ((k / 3) % 4), 2'((k / 3) % 4),
              (k == 12));
      end

      // Interruption by en=0 mid-slot at index 2
      en0 = 1'b0;
      tick();
      chk0("int_off", 4'b0000, 2'd0, 1'b0);
      en0 = 1'b1;
      for (int k = 0; k < 8; k++) tick();
      chk0("int_mid2", 4'b0100, 2'd2, 1'b0);
      en0 = 1'b0;
      tick();
      chk0("int_pulse", 4'b0000, 2'd0, 1'b0);
      en0 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk0($sformatf("int_re%0d", k), 4'b0001, 2'd0, 1'b0);
      end
      tick();
      chk0("int_re3", 4'b0010, 2'd1, 1'b0);

      // Interruption by a one-cycle manual select
      for (int k = 0; k < 4; k++) tick();
      chk0("mm_mid2", 4'b0100, 2'd2, 1'b0);
      mode0 = 1'b0; in0 = 2'b01;
      tick();
      chk0("mm_man", 4'b0010, 2'd1, 1'b0);
      mode0 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk0($sformatf("mm_re%0d", k), 4'b0001, 2'd0, 1'b0);
      end
      tick();
      chk0("mm_re3", 4'b0010, 2'd1, 1'b0);

      // SEL_W=1, PRESCALE=1, ACTIVE_LOW=1 scan
      en1 = 1'b1; mode1 = 1'b1;
      for (int j = 0; j < 6; j++) begin
         tick();
         check($sformatf("c1_out%0d", j), 8'(out1), (j % 2 == 0) ? 8'b10 : 8'b01);
         check($sformatf("c1_wrap%0d", j), 8'(wrap1), 8'((j % 2 == 0) && (j > 0)));
      end

      // SEL_W=3 manual
      en3 = 1'b1; mode3 = 1'b0; in3 = 3'b101;
      tick();
      check("c3_out", out3, 8'b0010_0000);
      check("c3_sel", 8'(sel3), 8'd5);
      in3 = 3'b000;
      tick();
      check("c3_out0", out3, 8'b0000_0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
